// File: rtl/seg_scan_if.sv
// seg_scan bus: display value/flags in, scanned segment word out.
interface seg_scan_if;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [11:0] out;
  logic [1:0]  digit_idx;
  logic        frame_done;

  modport master (
    output enable, load, value, dp_in, blank_in,
    input  out, digit_idx, frame_done
  );

  modport slave (
    input  enable, load, value, dp_in, blank_in,
    output out, digit_idx, frame_done
  );
endinterface

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment scanner with ghost blanking
// and frame-synchronous (tear-free) display updates.
module seg_scan #(
  parameter int CLK_DIV        = 50000,
  parameter int BLANK          = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [3:0] SEL_OFF =
    (SEL_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
  localparam logic [7:0] SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [11:0] OUT_OFF = {SEL_OFF, SEG_OFF};

  logic [CW-1:0] cnt;
  logic [1:0]    dig;
  logic [15:0]   sh_val, ac_val;
  logic [3:0]    sh_dp, ac_dp;
  logic [3:0]    sh_blk, ac_blk;

  logic          last, frame_end, blank_win, lit;
  logic [3:0]    nib, sel;
  logic [6:0]    font;
  logic [7:0]    seg;
  logic [11:0]   out_nx;

  assign last      = (cnt == LAST);
  assign frame_end = bus.enable && last && (dig == 2'd3);

  if (BLANK == 0) begin : g_noblank
    assign blank_win = 1'b0;
  end else begin : g_blank
    localparam logic [CW-1:0] BLK = CW'(BLANK);
    assign blank_win = (cnt < BLK);
  end

  assign lit = bus.enable && !blank_win;
  assign nib = ac_val[{dig, 2'b00} +: 4];

  // Font bits ordered A..G, A in the MSB.
  always_comb begin
    font = 7'h00;
    case (nib)
      4'h0: font = 7'h7E;
      4'h1: font = 7'h30;
      4'h2: font = 7'h6D;
      4'h3: font = 7'h79;
      4'h4: font = 7'h33;
      4'h5: font = 7'h5B;
      4'h6: font = 7'h5F;
      4'h7: font = 7'h70;
      4'h8: font = 7'h7F;
      4'h9: font = 7'h7B;
      4'hA: font = 7'h77;
      4'hB: font = 7'h1F;
      4'hC: font = 7'h4E;
      4'hD: font = 7'h3D;
      4'hE: font = 7'h4F;
      4'hF: font = 7'h47;
      default: font = 7'h00;
    endcase
  end

  always_comb begin
    sel = 4'h0;
    seg = 8'h00;
    if (lit) begin
      sel[dig] = 1'b1;
      if (!ac_blk[dig]) seg = {font, ac_dp[dig]};
    end
    out_nx = {sel ^ SEL_OFF, seg ^ SEG_OFF};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      dig            <= 2'd0;
      sh_val         <= 16'h0;
      sh_dp          <= 4'h0;
      sh_blk         <= 4'h0;
      ac_val         <= 16'h0;
      ac_dp          <= 4'h0;
      ac_blk         <= 4'h0;
      bus.out        <= OUT_OFF;
      bus.digit_idx  <= 2'd0;
      bus.frame_done <= 1'b0;
    end else begin
      if (bus.load) begin
        sh_val <= bus.value;
        sh_dp  <= bus.dp_in;
        sh_blk <= bus.blank_in;
      end
      if (!bus.enable) begin
        cnt <= '0;
      end else if (last) begin
        cnt <= '0;
        dig <= dig + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // A load coincident with frame end bypasses the shadow.
      if (frame_end) begin
        ac_val <= bus.load ? bus.value    : sh_val;
        ac_dp  <= bus.load ? bus.dp_in    : sh_dp;
        ac_blk <= bus.load ? bus.blank_in : sh_blk;
      end
      bus.out        <= out_nx;
      bus.digit_idx  <= dig;
      bus.frame_done <= frame_end;
    end
  end

endmodule
